// File: rtl/design2_wrapper.sv
// True dual-port byte-writable RAM, read-first on both ports, shared clock and async active-low reset.
// Define DPRAM_OUTREG_EN to add a second output register per port (read latency 2).
module design2_wrapper #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic [31:0]           addra,
  input  logic [DATA_W-1:0]     dina,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic                  ena,
  output logic [DATA_W-1:0]     douta,
  input  logic [31:0]           addrb,
  input  logic [DATA_W-1:0]     dinb,
  input  logic [DATA_W/8-1:0]   web,
  input  logic                  enb,
  output logic [DATA_W-1:0]     doutb
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx_a, idx_b;
  logic              unused_addr_hi;

  // Upper address bits alias onto the decoded range.
  assign idx_a          = addra[ADDR_W-1:0];
  assign idx_b          = addrb[ADDR_W-1:0];
  assign unused_addr_hi = ^{addra[31:ADDR_W], addrb[31:ADDR_W]};

  // Reset release goes through two flops; assertion is seen immediately.
  logic [1:0] rst_sync_q;
  logic       live;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign live = rst_sync_q[1];

  // NOTE: the array has no reset; only the read-data registers are cleared.
  // B lanes are written first so that A wins lanes both ports enable.
  always_ff @(posedge clka) begin
    if (live) begin
      for (int i = 0; i < NB; i++) begin
        if (enb && web[i]) mem[idx_b][8*i +: 8] <= dinb[8*i +: 8];
        if (ena && wea[i]) mem[idx_a][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  // Reading the array in the same edge as the write returns the old word (read-first).
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (live && ena) rd_a_d = mem[idx_a];
    if (live && enb) rd_b_d = mem[idx_b];
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic              ld_a_q, ld_b_q;
  logic [DATA_W-1:0] pipe_a_q, pipe_b_q;

  // Second stage follows the first one edge later, only when the first stage loaded.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ld_a_q   <= 1'b0;
      ld_b_q   <= 1'b0;
      pipe_a_q <= '0;
      pipe_b_q <= '0;
    end else begin
      ld_a_q <= live & ena;
      ld_b_q <= live & enb;
      if (ld_a_q) pipe_a_q <= rd_a_q;
      if (ld_b_q) pipe_b_q <= rd_b_q;
    end
  end

  assign douta = pipe_a_q;
  assign doutb = pipe_b_q;
`else
  assign douta = rd_a_q;
  assign doutb = rd_b_q;
`endif

endmodule

// File: tb/tb_design2_wrapper.sv
// Self-checking bench for design2_wrapper: directed scenarios plus a randomized phase against a word-array model.
module tb_design2_wrapper;

`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int NRND  = 300;

  logic        clka, rsta_n;
  logic [31:0] addra, dina, douta, addrb, dinb, doutb;
  logic [3:0]  wea, web;
  logic        ena, enb;

  design2_wrapper #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clka  (clka),
    .rsta_n(rsta_n),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .ena   (ena),
    .douta (douta),
    .addrb (addrb),
    .dinb  (dinb),
    .web   (web),
    .enb   (enb),
    .doutb (doutb)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  logic [31:0] model [DEPTH];
  logic [31:0] written [1:100];
  logic [31:0] exp_a, exp_b;
  int n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  // One edge of the memory as the specification describes it: read old words, then merge writes, A last.
  task automatic model_edge(input logic ea, input logic [31:0] aa, input logic [31:0] da, input logic [3:0] wa,
                            input logic eb, input logic [31:0] ab, input logic [31:0] db, input logic [3:0] wb,
                            output logic [31:0] ra, output logic [31:0] rb);
    logic [31:0] mb, ma;
    ra = model[aa[AW-1:0]];
    rb = model[ab[AW-1:0]];
    mb = lane_mask(wb);
    ma = lane_mask(wa);
    if (eb) model[ab[AW-1:0]] = (model[ab[AW-1:0]] & ~mb) | (db & mb);
    if (ea) model[aa[AW-1:0]] = (model[aa[AW-1:0]] & ~ma) | (da & ma);
  endtask

  // Drive one access on each enabled port, then idle until the read data is due.
  task automatic access(input logic ea, input logic [31:0] aa, input logic [31:0] da, input logic [3:0] wa,
                        input logic eb, input logic [31:0] ab, input logic [31:0] db, input logic [3:0] wb);
    logic [31:0] ra, rb;
    ena = ea; addra = aa; dina = da; wea = wa;
    enb = eb; addrb = ab; dinb = db; web = wb;
    tick();
    model_edge(ea, aa, da, wa, eb, ab, db, wb, ra, rb);
    if (ea) exp_a = ra;
    if (eb) exp_b = rb;
    ena = 1'b0; wea = 4'h0;
    enb = 1'b0; web = 4'h0;
    repeat (LAT - 1) tick();
  endtask

  logic [31:0] hist_a [NRND];
  logic [31:0] hist_b [NRND];
  logic        hen_a  [NRND];
  logic        hen_b  [NRND];

  initial begin
    logic [31:0] pre_a, pre_b, want_a, want_b, ra, rb, w;
    logic        ea, eb;
    logic [31:0] aa, ab, da, db;
    logic [3:0]  wa, wb;

    n_cmp = 0; n_err = 0;
    exp_a = '0; exp_b = '0;
    rsta_n = 1'b0;
    ena = 0; enb = 0; wea = 0; web = 0;
    addra = 0; addrb = 0; dina = 0; dinb = 0;
    repeat (3) tick();
    rsta_n = 1'b1;
    repeat (3) tick();
    check("reset_douta", douta, 32'h0);
    check("reset_doutb", doutb, 32'h0);

    // Asynchronous reset in mid-cycle; a write attempted while in reset is dropped.
    access(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 4'h0);
    access(1, 3, 0, 4'h0, 1, 3, 0, 4'h0);
    check("pre_rst_douta", douta, 32'hDEADBEEF);
    check("pre_rst_doutb", doutb, 32'hDEADBEEF);
    #2 rsta_n = 1'b0;
    #1;
    check("async_rst_douta", douta, 32'h0);
    check("async_rst_doutb", doutb, 32'h0);
    ena = 1; addra = 3; dina = 32'h0; wea = 4'hF;
    enb = 1; addrb = 3;
    repeat (2) tick();
    check("in_rst_douta", douta, 32'h0);
    check("in_rst_doutb", doutb, 32'h0);
    ena = 0; enb = 0; wea = 0;
    rsta_n = 1'b1;
    repeat (3) tick();
    check("post_rst_douta", douta, 32'h0);
    check("post_rst_doutb", doutb, 32'h0);
    access(1, 3, 0, 4'h0, 1, 3, 0, 4'h0);
    check("rst_blocked_wr_a", douta, 32'hDEADBEEF);
    check("rst_blocked_wr_b", doutb, 32'hDEADBEEF);

    // Port A fills 1..100, port B reads them back.
    for (int i = 1; i <= 100; i++) begin
      written[i] = $urandom;
      access(1, i, written[i], 4'hF, 0, 0, 0, 4'h0);
    end
    for (int i = 1; i <= 100; i++) begin
      access(0, 0, 0, 4'h0, 1, i, 0, 4'h0);
      check($sformatf("a_wr_b_rd_%0d", i), doutb, written[i]);
    end

    // Byte lanes.
    access(1, 5, 32'h11223344, 4'hF, 0, 0, 0, 4'h0);
    access(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 4'h0);
    access(0, 0, 0, 4'h0, 1, 5, 0, 4'h0);
    check("byte_en", doutb, 32'h11BB33DD);

    // Same-word collision: A wins, both ports read the old word.
    access(1, 7, 32'h01020304, 4'hF, 0, 0, 0, 4'h0);
    access(1, 7, 32'hAAAAAAAA, 4'hF, 1, 7, 32'h55555555, 4'b1100);
    check("coll_old_a", douta, 32'h01020304);
    check("coll_old_b", doutb, 32'h01020304);
    access(1, 7, 0, 4'h0, 1, 7, 0, 4'h0);
    check("coll_new_a", douta, 32'hAAAAAAAA);
    check("coll_new_b", doutb, 32'hAAAAAAAA);

    // Cross-port read during write.
    access(1, 9, 32'h12345678, 4'hF, 0, 0, 0, 4'h0);
    access(1, 9, 32'hCAFEF00D, 4'hF, 1, 9, 0, 4'h0);
    check("rdw_old", doutb, 32'h12345678);
    access(0, 0, 0, 4'h0, 1, 9, 0, 4'h0);
    check("rdw_new", doutb, 32'hCAFEF00D);

    // Disabled port holds while its address moves.
    enb = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      addrb = 32'(k * 3);
      tick();
      check($sformatf("enb_hold_%0d", k), doutb, 32'hCAFEF00D);
    end

    // Aliasing of the ignored upper address bits.
    access(1, 32'h400, 32'h0BADCAFE, 4'hF, 0, 0, 0, 4'h0);
    access(1, 32'h800, 0, 4'h0, 1, 0, 0, 4'h0);
    check("alias_b_at_0", doutb, 32'h0BADCAFE);
    check("alias_a_at_800", douta, 32'h0BADCAFE);

    // Randomized phase over a small window so ports collide often.
    for (int i = 0; i < 16; i++) access(1, i, $urandom, 4'hF, 0, 0, 0, 4'h0);
    access(1, 0, 0, 4'h0, 1, 1, 0, 4'h0);
    pre_a = exp_a;
    pre_b = exp_b;
    for (int t = 0; t < NRND; t++) begin
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      aa = ($urandom_range(0, 3) << AW) | $urandom_range(0, 15);
      ab = ($urandom_range(0, 3) << AW) | $urandom_range(0, 15);
      da = $urandom; db = $urandom;
      wa = 4'($urandom); wb = 4'($urandom);
      ena = ea; addra = aa; dina = da; wea = wa;
      enb = eb; addrb = ab; dinb = db; web = wb;
      tick();
      model_edge(ea, aa, da, wa, eb, ab, db, wb, ra, rb);
      hist_a[t] = ra; hen_a[t] = ea;
      hist_b[t] = rb; hen_b[t] = eb;
      // Output shows the newest enabled access that is at least LAT-1 edges old.
      want_a = pre_a;
      want_b = pre_b;
      for (int j = t - LAT + 1; j >= 0; j--) if (hen_a[j]) begin want_a = hist_a[j]; break; end
      for (int j = t - LAT + 1; j >= 0; j--) if (hen_b[j]) begin want_b = hist_b[j]; break; end
      check($sformatf("rnd_a_%0d", t), douta, want_a);
      check($sformatf("rnd_b_%0d", t), doutb, want_b);
    end
    ena = 0; enb = 0; wea = 0; web = 0;

    // Final sweep of the random window from port A.
    for (int i = 0; i < 16; i++) begin
      w = model[i];
      access(1, i, 0, 4'h0, 0, 0, 0, 4'h0);
      check($sformatf("sweep_%0d", i), douta, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
